// File: rtl/cdb_arbiter.sv
// cdb_arbiter: Common Data Bus arbiter.
// Each cycle it grants up to WAYS completing functional units. Priority
// rotates round-robin from rr_ptr. The granted results are registered onto
// the CDB lanes one cycle later. A squash blocks every grant for that cycle,
// so the bus is empty on the next cycle.
//
// Ports:
//   clock          single clock, posedge
//   reset          asynchronous, active-low
//   squash         synchronous flush; no grants this cycle
//   fu_valid       per-FU completed-result request
//   fu_rob_idx     per-FU ROB index   (NUM_FU x $clog2(ROB), FU i at [i*W +: W])
//   fu_prn         per-FU dest PRN    (NUM_FU x $clog2(PRF))
//   fu_value       per-FU result      (NUM_FU x XLEN)
//   fu_direction   per-FU branch direction
//   fu_target      per-FU branch target (NUM_FU x XLEN)
//   fu_ready       per-FU grant, combinational
//   CDB_*          registered lane outputs (WAYS lanes, lane k at [k*W +: W])
module cdb_arbiter #(
  parameter int unsigned WAYS   = 2,
  parameter int unsigned NUM_FU = 6,
  parameter int unsigned ROB    = 32,
  parameter int unsigned PRF    = 64,
  parameter int unsigned XLEN   = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU*$clog2(ROB)-1:0]    fu_rob_idx,
  input  logic [NUM_FU*$clog2(PRF)-1:0]    fu_prn,
  input  logic [NUM_FU*XLEN-1:0]           fu_value,
  input  logic [NUM_FU-1:0]                fu_direction,
  input  logic [NUM_FU*XLEN-1:0]           fu_target,
  output logic [NUM_FU-1:0]                fu_ready,
  output logic [WAYS-1:0]                  CDB_valid,
  output logic [WAYS*$clog2(ROB)-1:0]      CDB_ROB_idx,
  output logic [WAYS*$clog2(PRF)-1:0]      CDB_PRN,
  output logic [WAYS*XLEN-1:0]             CDB_value,
  output logic [WAYS-1:0]                  CDB_direction,
  output logic [WAYS*XLEN-1:0]             CDB_target
);

  localparam int unsigned RW  = $clog2(ROB);
  localparam int unsigned NW  = $clog2(PRF);
  localparam int unsigned PW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned LIW = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        next_ptr;
  logic [NUM_FU-1:0]    grant;
  logic [WAYS-1:0]      lane_hit;
  logic [PW-1:0]        lane_sel [WAYS];

  logic [WAYS*RW-1:0]   lane_rob;
  logic [WAYS*NW-1:0]   lane_prn;
  logic [WAYS*XLEN-1:0] lane_val;
  logic [WAYS-1:0]      lane_dir;
  logic [WAYS*XLEN-1:0] lane_tgt;

  // Rotating scan: the offset j walks from rr_ptr and wraps by subtraction,
  // so NUM_FU does not have to be a power of two. The k-th hit goes to lane k.
  // Grants are also gated by reset so fu_ready is 0 while reset is held.
  always_comb begin : grant_scan
    int unsigned idx;
    int unsigned cnt;
    grant    = '0;
    lane_hit = '0;
    next_ptr = rr_ptr;
    idx      = 0;
    cnt      = 0;
    for (int unsigned k = 0; k < WAYS; k++) lane_sel[k] = '0;
    if (reset && !squash) begin
      for (int unsigned j = 0; j < NUM_FU; j++) begin
        idx = 32'(rr_ptr) + j;
        if (idx >= NUM_FU) idx = idx - NUM_FU;
        if (fu_valid[PW'(idx)] && cnt < WAYS) begin
          grant[PW'(idx)]         = 1'b1;
          lane_hit[LIW'(cnt)]     = 1'b1;
          lane_sel[LIW'(cnt)]     = PW'(idx);
          cnt                     = cnt + 1;
          next_ptr                = (idx == NUM_FU - 1) ? '0 : PW'(idx + 1);
        end
      end
    end
  end

  // Payload steering from the selected FU to each lane.
  always_comb begin : lane_mux
    lane_rob = '0;
    lane_prn = '0;
    lane_val = '0;
    lane_dir = '0;
    lane_tgt = '0;
    for (int unsigned k = 0; k < WAYS; k++) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (lane_sel[k] == PW'(i)) begin
          lane_rob[k*RW +: RW]     = fu_rob_idx[i*RW +: RW];
          lane_prn[k*NW +: NW]     = fu_prn[i*NW +: NW];
          lane_val[k*XLEN +: XLEN] = fu_value[i*XLEN +: XLEN];
          lane_dir[k]              = fu_direction[i];
          lane_tgt[k*XLEN +: XLEN] = fu_target[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign fu_ready = grant;

  // A squash produces no grants, so lane_hit is all zero. That clears
  // CDB_valid, holds the payloads and leaves rr_ptr unchanged.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr        <= '0;
      CDB_valid     <= '0;
      CDB_ROB_idx   <= '0;
      CDB_PRN       <= '0;
      CDB_value     <= '0;
      CDB_direction <= '0;
      CDB_target    <= '0;
    end else begin
      rr_ptr    <= next_ptr;
      CDB_valid <= lane_hit;
      for (int unsigned k = 0; k < WAYS; k++) begin
        if (lane_hit[k]) begin
          CDB_ROB_idx[k*RW +: RW]  <= lane_rob[k*RW +: RW];
          CDB_PRN[k*NW +: NW]      <= lane_prn[k*NW +: NW];
          CDB_value[k*XLEN +: XLEN] <= lane_val[k*XLEN +: XLEN];
          CDB_direction[k]         <= lane_dir[k];
          CDB_target[k*XLEN +: XLEN] <= lane_tgt[k*XLEN +: XLEN];
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (WAYS=2, NUM_FU=6).
// For each cycle the bench predicts the grant vector and the next lane
// contents. It pushes the lane contents to a queue and pops them after the
// edge, where they are compared with the registered CDB outputs.
module tb_cdb_arbiter;

  logic         clock;
  logic         reset;
  logic         squash;
  logic [5:0]   fu_valid;
  logic [29:0]  fu_rob_idx;
  logic [35:0]  fu_prn;
  logic [191:0] fu_value;
  logic [5:0]   fu_direction;
  logic [191:0] fu_target;
  logic [5:0]   fu_ready;
  logic [1:0]   CDB_valid;
  logic [9:0]   CDB_ROB_idx;
  logic [11:0]  CDB_PRN;
  logic [63:0]  CDB_value;
  logic [1:0]   CDB_direction;
  logic [63:0]  CDB_target;

  cdb_arbiter #(.WAYS(2), .NUM_FU(6), .ROB(32), .PRF(64), .XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .squash        (squash),
    .fu_valid      (fu_valid),
    .fu_rob_idx    (fu_rob_idx),
    .fu_prn        (fu_prn),
    .fu_value      (fu_value),
    .fu_direction  (fu_direction),
    .fu_target     (fu_target),
    .fu_ready      (fu_ready),
    .CDB_valid     (CDB_valid),
    .CDB_ROB_idx   (CDB_ROB_idx),
    .CDB_PRN       (CDB_PRN),
    .CDB_value     (CDB_value),
    .CDB_direction (CDB_direction),
    .CDB_target    (CDB_target)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  v;
    logic [9:0]  rob;
    logic [11:0] prn;
    logic [63:0] val;
    logic [1:0]  dir;
    logic [63:0] tgt;
  } lanes_t;

  lanes_t     sb[$];
  lanes_t     cur;
  int         m_ptr;
  int         ser [6];
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic load_payload(input int i);
    fu_rob_idx[i*5 +: 5]    = 5'((i * 7 + ser[i] * 3) % 32);
    fu_prn[i*6 +: 6]        = 6'((i * 11 + ser[i] * 5) % 64);
    fu_value[i*32 +: 32]    = $urandom;
    fu_direction[i]         = 1'($urandom_range(0, 1));
    fu_target[i*32 +: 32]   = $urandom;
  endtask

  // Inputs are set just after an edge. Predict, check fu_ready, push the
  // expected lanes, then after the edge pop them and compare with the CDB.
  task automatic step();
    lanes_t     e;
    lanes_t     got;
    logic [5:0] rdy;
    int         g;
    int         idx;
    int         nptr;
    #1;
    rdy  = '0;
    g    = 0;
    nptr = m_ptr;
    e    = cur;
    e.v  = '0;
    if (!squash) begin
      for (int j = 0; j < 6; j++) begin
        idx = (m_ptr + j) % 6;
        if (fu_valid[idx] && g < 2) begin
          rdy[idx]            = 1'b1;
          e.v[g]              = 1'b1;
          e.rob[g*5 +: 5]     = fu_rob_idx[idx*5 +: 5];
          e.prn[g*6 +: 6]     = fu_prn[idx*6 +: 6];
          e.val[g*32 +: 32]   = fu_value[idx*32 +: 32];
          e.dir[g]            = fu_direction[idx];
          e.tgt[g*32 +: 32]   = fu_target[idx*32 +: 32];
          g++;
          nptr = (idx + 1) % 6;
        end
      end
    end
    check("fu_ready", 64'(fu_ready), 64'(rdy));
    sb.push_back(e);
    m_ptr = nptr;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 64'(1), 64'(0));
    end else begin
      e   = sb.pop_front();
      got = '{v: CDB_valid, rob: CDB_ROB_idx, prn: CDB_PRN, val: CDB_value,
              dir: CDB_direction, tgt: CDB_target};
      check("CDB_valid", 64'(got.v), 64'(e.v));
      check("CDB_ROB_idx", 64'(got.rob), 64'(e.rob));
      check("CDB_PRN", 64'(got.prn), 64'(e.prn));
      check("CDB_value", got.val, e.val);
      check("CDB_direction", 64'(got.dir), 64'(e.dir));
      check("CDB_target", got.tgt, e.tgt);
      cur = e;
    end
    for (int i = 0; i < 6; i++) begin
      if (rdy[i]) begin
        ser[i]++;
        load_payload(i);
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    cur   = '0;
    m_ptr = 0;
  endtask

  initial begin
    logic [5:0] full_exp [4];
    n_checks = 0;
    n_pass   = 0;
    full_exp[0] = 6'b000011;
    full_exp[1] = 6'b001100;
    full_exp[2] = 6'b110000;
    full_exp[3] = 6'b000011;
    for (int i = 0; i < 6; i++) begin
      ser[i] = 0;
      load_payload(i);
    end
    reset    = 1'b0;
    squash   = 1'b0;
    fu_valid = 6'b111111;
    model_reset();

    // Reset held with every FU requesting.
    repeat (3) @(posedge clock);
    #2;
    check("rst_fu_ready", 64'(fu_ready), 64'(0));
    check("rst_CDB_valid", 64'(CDB_valid), 64'(0));
    check("rst_CDB_ROB_idx", 64'(CDB_ROB_idx), 64'(0));
    check("rst_CDB_value", CDB_value, 64'(0));
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rel_fu_ready", 64'(fu_ready), 64'(6'b000011));
    @(posedge clock);
    #1;
    // That first edge granted FU0 and FU1. Clear the model to reflect it.
    cur.v = 2'b11;
    cur.rob = {fu_rob_idx[9:5], fu_rob_idx[4:0]};
    cur.prn = {fu_prn[11:6], fu_prn[5:0]};
    cur.val = {fu_value[63:32], fu_value[31:0]};
    cur.dir = fu_direction[1:0];
    cur.tgt = {fu_target[63:32], fu_target[31:0]};
    check("rel_CDB_valid", 64'(CDB_valid), 64'(2'b11));
    check("rel_CDB_ROB_idx", 64'(CDB_ROB_idx), 64'(cur.rob));
    m_ptr = 2;
    for (int i = 0; i < 2; i++) begin
      ser[i]++;
      load_payload(i);
    end

    // Move pointer back to 0: FU4, FU5 only (from ptr 2).
    fu_valid = 6'b110000;
    step();

    // Single requester FU1 with ROB 5, PRN 17.
    fu_valid = 6'b000010;
    fu_rob_idx[9:5] = 5'd5;
    fu_prn[11:6]    = 6'd17;
    #1;
    check("single_fu_ready", 64'(fu_ready), 64'(6'b000010));
    step();
    check("single_CDB_valid", 64'(CDB_valid), 64'(2'b01));
    check("single_CDB_ROB_idx0", 64'(CDB_ROB_idx[4:0]), 64'(5));
    check("single_CDB_PRN0", 64'(CDB_PRN[5:0]), 64'(17));

    // Pointer now 2. Grant FU4, FU5 to return to 0, then full load.
    fu_valid = 6'b110000;
    step();
    fu_valid = 6'b111111;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("full_fu_ready", 64'(fu_ready), 64'(full_exp[c]));
      step();
      check("full_CDB_valid", 64'(CDB_valid), 64'(2'b11));
    end

    // Pointer 2. Grant FU4 alone -> pointer 5. Then FU5+FU0 wrap.
    fu_valid = 6'b010000;
    step();
    fu_valid = 6'b100001;
    #1;
    check("wrap_fu_ready", 64'(fu_ready), 64'(6'b100001));
    step();
    check("wrap_lane0_rob", 64'(CDB_ROB_idx[4:0]), 64'(cur.rob[4:0]));
    // Pointer 1: with all valid, FU1 and FU2 are next.
    fu_valid = 6'b111111;
    #1;
    check("wrap_ptr1", 64'(fu_ready), 64'(6'b000110));

    // Squash with everything requesting. Pointer stays at 1.
    squash = 1'b1;
    #1;
    check("squash_fu_ready", 64'(fu_ready), 64'(0));
    step();
    check("squash_CDB_valid", 64'(CDB_valid), 64'(0));
    squash = 1'b0;
    #1;
    check("post_squash_ready", 64'(fu_ready), 64'(6'b000110));
    step();

    // Random traffic. A request is held until it is granted.
    for (int c = 0; c < 300; c++) begin
      logic [5:0] keep;
      keep     = fu_valid & ~fu_ready;
      fu_valid = keep | 6'($urandom_range(0, 63));
      squash   = ($urandom_range(0, 9) == 0);
      step();
    end
    squash = 1'b0;

    // Reset pulled between edges during a full-load burst.
    fu_valid = 6'b111111;
    step();
    step();
    #2;
    reset = 1'b0;
    #1;
    check("midrst_CDB_valid", 64'(CDB_valid), 64'(0));
    check("midrst_fu_ready", 64'(fu_ready), 64'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst_restart", 64'(fu_ready), 64'(6'b000011));
    @(posedge clock);
    #1;
    fu_valid = 6'b000000;
    check("midrst_CDB_valid1", 64'(CDB_valid), 64'(2'b11));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the N-way out-of-order core. It sits between the functional-unit completion ports and the `WAYS` CDB lanes that feed the ROB, RS wakeup and PRF write ports. Each cycle it grants up to `WAYS` completing functional units using rotating (round-robin) priority, and registers their results onto the CDB one cycle later. A branch-misprediction squash blocks all grants for one cycle and clears the bus.

## Interface
- `WAYS`, 2: number of CDB lanes, equal to the core's superscalar width.
- `NUM_FU`, 6: number of functional-unit completion requesters; must be at least `WAYS`.
- `ROB`, 32: ROB entries; ROB index width is $clog2(ROB).
- `PRF`, 64: physical registers; PRN width is $clog2(PRF).
- `XLEN`, 32: data and target width.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `squash`  in  1  synchronous flush (branch mispredict).
- `fu_valid`  in  NUM_FU  requester has a completed result.
- `fu_rob_idx`  in  NUM_FU x $clog2(ROB)  ROB entry of the result.
- `fu_prn`  in  NUM_FU x $clog2(PRF)  destination physical register.
- `fu_value`  in  NUM_FU x XLEN  result value.
- `fu_direction`  in  NUM_FU  resolved branch direction.
- `fu_target`  in  NUM_FU x XLEN  resolved branch target.
- `fu_ready`  out  NUM_FU  grant; combinational, same cycle.
- `CDB_valid`  out  WAYS  lane carries a result (registered).
- `CDB_ROB_idx`  out  WAYS x $clog2(ROB)  registered.
- `CDB_PRN`  out  WAYS x $clog2(PRF)  registered.
- `CDB_value`  out  WAYS x XLEN  registered.
- `CDB_direction`  out  WAYS  registered.
- `CDB_target`  out  WAYS x XLEN  registered.

## Operation
**State**
- `rr_ptr`, $clog2(NUM_FU) bits: index of the highest-priority requester.
- CDB lane registers.

**Grant (combinational)**
- Scan requesters in order `rr_ptr`, `rr_ptr+1`, …, wrapping modulo NUM_FU.
- The first `WAYS` requesters with `fu_valid` high get `fu_ready=1`.
- `fu_ready[i]` is never 1 when `fu_valid[i]` is 0.
- When `squash` is high, all `fu_ready` are 0.

**Handshake**
- A requester holds `fu_valid` and its payload stable until it samples `fu_ready=1` at a posedge.
- The transfer completes at that edge.
- A requester that is not granted keeps requesting. It is not dropped.

**Lane assignment (at posedge)**
- The k-th grant in scan order goes to lane k.
- `CDB_valid` is 1 for lanes 0..g-1, where g is the number of grants, and 0 for the rest.
- Payload registers of unused lanes hold their previous values.

**Pointer update**
- If g > 0: `rr_ptr` <= (index of the last granted requester + 1) mod NUM_FU.
- If g = 0: `rr_ptr` is unchanged.
- Wrap rule: when the increment equals NUM_FU, the pointer goes to 0. Non-power-of-2 NUM_FU must be supported.

**Squash**
- `CDB_valid` <= 0 at the next edge.
- `rr_ptr` is unchanged.
- Requesters keep their own state. The FUs flush themselves.

**Reset**
- While `reset` is low, asynchronously: `CDB_valid`=0, all CDB payloads=0, `rr_ptr`=0.
- `fu_ready` is forced to 0.
- These apply even in the middle of a burst.

## Timing
- Grant is combinational from `fu_valid`, `rr_ptr` and `squash`, within the same cycle.
- Latency from `fu_valid`-and-granted to `CDB_valid` is 1 cycle.
- Throughput is up to `WAYS` results per cycle.
- Under continuous full load, every requester is granted within ceil(NUM_FU/WAYS) cycles. No starvation.
- `squash` takes effect in the cycle it is asserted; the bus is clear on the following cycle.
- The first grant is possible in the first cycle after `reset` deasserts.

## Test plan
- **Reset:** hold `reset` low with all `fu_valid`=1 -> `fu_ready`=0, `CDB_valid`=2'b00, `rr_ptr`=0; release -> grants to FU0 and FU1 that cycle.
- **Single requester:** only FU1 valid, `fu_rob_idx[1]`=5, `fu_prn[1]`=17 -> `fu_ready`=6'b000010 that cycle; next cycle `CDB_valid`=2'b01, `CDB_ROB_idx[0]`=5, `CDB_PRN[0]`=17; `rr_ptr`=2.
- **Full load with wrap:** all 6 valid, `rr_ptr`=0, held 4 cycles -> grants {0,1}, {2,3}, {4,5}, {0,1}; `CDB_valid`=2'b11 every cycle after the first; `rr_ptr` sequence 2, 4, 0, 2.
- **Wrap-around ordering:** `rr_ptr`=5, FU5 and FU0 valid -> lane0 carries FU5's payload, lane1 carries FU0's payload; `rr_ptr`=1.
- **Squash:** all valid, `squash`=1 for one cycle -> `fu_ready`=0 that cycle; next cycle `CDB_valid`=0 and `rr_ptr` unchanged; the cycle after, normal grants resume from the same pointer.
- **Reset mid-operation:** pull `reset` low between edges during the full-load burst -> `CDB_valid` goes to 0 immediately, without waiting for an edge; after release, arbitration restarts at FU0.
